// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencing controller: load-use and HI/LO interlocks, branch kill,
// imem wait absorption, mult/div occupancy tracking and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        d_is_md,
    input  logic        d_md_div,
    input  logic        d_reads_hilo,
    input  logic [4:0]  e_wr_reg,
    input  logic        e_is_load,
    input  logic        branch_taken,
    input  logic        imem_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t        md_state_reg, md_state_next;
    logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;
    logic             md_done_reg, md_done_next;
    logic [15:0]      stall_cnt_reg, stall_cnt_next;

    logic [1:0][4:0]  d_src;
    logic [1:0]       d_use;
    logic [1:0]       src_match;
    logic             load_use;
    logic             md_stall;
    logic             hazard;
    logic             md_accept;

    assign d_src = {d_rt, d_rs};
    assign d_use = {d_use_rt, d_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = d_use[gi] && (d_src[gi] == e_wr_reg);
        end
    endgenerate

    // r0 writes are architecturally discarded, so they never create a dependency
    assign load_use  = e_is_load && (e_wr_reg != 5'd0) && (|src_match);
    assign md_stall  = (md_state_reg == BUSY) && (d_reads_hilo || d_is_md);
    assign hazard    = load_use || md_stall;
    assign md_accept = d_is_md && !hazard;

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        if (!reset) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (hazard) begin
            // hold F and D; D re-evaluates its branch once the hazard clears
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end else if (branch_taken) begin
            fd_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
        end
    end

    always_comb begin
        md_state_next = md_state_reg;
        md_cnt_next   = md_cnt_reg;
        md_done_next  = 1'b0;
        case (md_state_reg)
            IDLE: begin
                if (md_accept) begin
                    md_cnt_next   = d_md_div ? DIV_CNT : MUL_CNT;
                    md_state_next = BUSY;
                end
            end
            BUSY: begin
                // counts down regardless of pipeline stalls or imem waits
                md_cnt_next = md_cnt_reg - CNT_W'(1);
                if (md_cnt_reg == CNT_W'(1)) begin
                    md_state_next = IDLE;
                    md_done_next  = 1'b1;
                end
            end
            default: begin
                md_state_next = IDLE;
                md_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!pc_en && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_state_reg  <= IDLE;
            md_cnt_reg    <= '0;
            md_done_reg   <= 1'b0;
            stall_cnt_reg <= 16'd0;
        end else begin
            md_state_reg  <= md_state_next;
            md_cnt_reg    <= md_cnt_next;
            md_done_reg   <= md_done_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign md_busy      = (md_state_reg == BUSY);
    assign md_done      = md_done_reg;
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed table, hand sequences for
// mult/div and reset corners, random stimulus against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wr_reg;
    logic        d_use_rs, d_use_rt, d_is_md, d_md_div, d_reads_hilo;
    logic        e_is_load, branch_taken, imem_ready;
    logic        pc_en, fd_en, fd_flush, de_flush, md_busy, md_done;
    logic [15:0] stall_cycles;

    pipe_hazard_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_is_md(d_is_md), .d_md_div(d_md_div), .d_reads_hilo(d_reads_hilo),
        .e_wr_reg(e_wr_reg), .e_is_load(e_is_load),
        .branch_taken(branch_taken), .imem_ready(imem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the mult/div unit is described by the edge number at
    // which its result becomes ready, not by a countdown.
    int cyc         = 0;
    int ready_at    = 0;
    bit result_owed = 0;
    int stall_model = 0;

    typedef struct {
        logic [4:0] rs, rt, wr;
        logic       use_rs, use_rt, is_load, br, imem;
        logic [3:0] ctrl;   // {pc_en, fd_en, fd_flush, de_flush}
    } vec_t;

    function automatic bit m_busy();
        return reset && (cyc < ready_at);
    endfunction

    function automatic bit m_hazard();
        bit lu;
        lu = e_is_load && (e_wr_reg != 0) &&
             ((d_use_rs && d_rs == e_wr_reg) || (d_use_rt && d_rt == e_wr_reg));
        return lu || (m_busy() && (d_reads_hilo || d_is_md));
    endfunction

    function automatic logic [3:0] exp_ctrl();
        if (!reset)       return 4'b0011;
        if (m_hazard())   return 4'b0001;
        if (branch_taken) return 4'b1110;
        if (!imem_ready)  return 4'b0110;
        return 4'b1100;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] c;
        c = exp_ctrl();
        chk({tag, ".pc_en"},    {15'd0, pc_en},    {15'd0, c[3]});
        chk({tag, ".fd_en"},    {15'd0, fd_en},    {15'd0, c[2]});
        chk({tag, ".fd_flush"}, {15'd0, fd_flush}, {15'd0, c[1]});
        chk({tag, ".de_flush"}, {15'd0, de_flush}, {15'd0, c[0]});
        chk({tag, ".md_busy"},  {15'd0, md_busy},  {15'd0, m_busy()});
        chk({tag, ".md_done"},  {15'd0, md_done},
            {15'd0, reset && result_owed && (cyc == ready_at)});
        chk({tag, ".stall"},    stall_cycles,      16'(stall_model));
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        logic [3:0] c;
        bit acc;
        bit dv;
        #1;
        check_all(tag);
        c   = exp_ctrl();
        acc = reset && d_is_md && !m_hazard();
        dv  = d_md_div;
        @(posedge clock);
        cyc++;
        if (reset) begin
            if (!c[3] && stall_model < 65535) stall_model++;
            if (acc) begin
                ready_at    = cyc + (dv ? 10 : 5);
                result_owed = 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        d_rs = 0; d_rt = 0; e_wr_reg = 0;
        d_use_rs = 0; d_use_rt = 0; d_is_md = 0; d_md_div = 0; d_reads_hilo = 0;
        e_is_load = 0; branch_taken = 0; imem_ready = 1;
    endtask

    vec_t vecs[11];

    initial begin
        int s0;
        reset = 1'b0;
        clear_inputs();

        vecs[0]  = '{rs:8, rt:0, wr:8, use_rs:1, use_rt:0, is_load:1, br:0, imem:1, ctrl:4'b0001};
        vecs[1]  = '{rs:0, rt:0, wr:0, use_rs:1, use_rt:0, is_load:1, br:0, imem:1, ctrl:4'b1100};
        vecs[2]  = '{rs:8, rt:0, wr:8, use_rs:0, use_rt:0, is_load:1, br:0, imem:1, ctrl:4'b1100};
        vecs[3]  = '{rs:0, rt:8, wr:8, use_rs:0, use_rt:1, is_load:1, br:0, imem:1, ctrl:4'b0001};
        vecs[4]  = '{rs:0, rt:8, wr:8, use_rs:0, use_rt:1, is_load:0, br:0, imem:1, ctrl:4'b1100};
        vecs[5]  = '{rs:9, rt:0, wr:8, use_rs:1, use_rt:0, is_load:1, br:0, imem:1, ctrl:4'b1100};
        vecs[6]  = '{rs:0, rt:0, wr:0, use_rs:0, use_rt:0, is_load:0, br:1, imem:0, ctrl:4'b1110};
        vecs[7]  = '{rs:0, rt:0, wr:0, use_rs:0, use_rt:0, is_load:0, br:0, imem:0, ctrl:4'b0110};
        vecs[8]  = '{rs:8, rt:0, wr:8, use_rs:1, use_rt:0, is_load:1, br:1, imem:1, ctrl:4'b0001};
        vecs[9]  = '{rs:8, rt:0, wr:8, use_rs:1, use_rt:0, is_load:0, br:1, imem:1, ctrl:4'b1110};
        vecs[10] = '{rs:3, rt:3, wr:3, use_rs:0, use_rt:0, is_load:1, br:0, imem:1, ctrl:4'b1100};

        // reset state
        step("reset0");
        step("reset1");
        reset = 1'b1;
        step("post_reset");

        // directed table (mult/div idle)
        foreach (vecs[i]) begin
            d_rs = vecs[i].rs; d_rt = vecs[i].rt; e_wr_reg = vecs[i].wr;
            d_use_rs = vecs[i].use_rs; d_use_rt = vecs[i].use_rt;
            e_is_load = vecs[i].is_load; branch_taken = vecs[i].br; imem_ready = vecs[i].imem;
            #1;
            chk($sformatf("vec%0d.ctrl", i), {12'd0, pc_en, fd_en, fd_flush, de_flush},
                {12'd0, vecs[i].ctrl});
            step($sformatf("vec%0d", i));
        end

        // multiply, then mflo held in D
        clear_inputs();
        d_is_md = 1;
        step("mul_issue");
        d_is_md = 0; d_reads_hilo = 1;
        s0 = stall_model;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mflo_wait%0d.busy", i), {15'd0, md_busy}, 16'd1);
            chk($sformatf("mflo_wait%0d.pc_en", i), {15'd0, pc_en}, 16'd0);
            step($sformatf("mflo_wait%0d", i));
        end
        #1;
        chk("mflo_go.pc_en", {15'd0, pc_en}, 16'd1);
        chk("mflo_go.md_done", {15'd0, md_done}, 16'd1);
        chk("mflo_go.stall", stall_cycles, 16'(s0 + 5));
        step("mflo_go");
        #1;
        chk("mflo_after.md_done", {15'd0, md_done}, 16'd0);
        clear_inputs();
        step("mflo_after");

        // divide, then a second divide waiting in D
        d_is_md = 1; d_md_div = 1;
        step("div1_issue");
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("div2_wait%0d.pc_en", i), {15'd0, pc_en}, 16'd0);
            step($sformatf("div2_wait%0d", i));
        end
        #1;
        chk("div2_accept.busy", {15'd0, md_busy}, 16'd0);
        chk("div2_accept.md_done", {15'd0, md_done}, 16'd1);
        chk("div2_accept.pc_en", {15'd0, pc_en}, 16'd1);
        step("div2_accept");
        #1;
        chk("div2_reload.busy", {15'd0, md_busy}, 16'd1);
        clear_inputs();
        for (int i = 0; i < 11; i++) step($sformatf("div2_run%0d", i));

        // branch during imem wait, then plain wait
        branch_taken = 1; imem_ready = 0;
        step("br_wait");
        branch_taken = 0;
        s0 = stall_model;
        step("imem_wait");
        #1;
        chk("imem_wait.stall_inc", stall_cycles, 16'(s0 + 1));
        clear_inputs();
        step("imem_resume");

        // reset while a divide is in flight
        d_is_md = 1; d_md_div = 1;
        step("rst_div_issue");
        d_is_md = 0;
        for (int i = 0; i < 3; i++) step($sformatf("rst_div_run%0d", i));
        #2;
        reset = 1'b0;
        ready_at = 0; result_owed = 0; stall_model = 0;
        #1;
        chk("rst_mid.busy", {15'd0, md_busy}, 16'd0);
        chk("rst_mid.stall", stall_cycles, 16'd0);
        @(negedge clock);
        step("rst_hold0");
        step("rst_hold1");
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("rst_release%0d.md_done", i), {15'd0, md_done}, 16'd0);
            step($sformatf("rst_release%0d", i));
        end

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            d_rs = 5'($urandom_range(0, 3));
            d_rt = 5'($urandom_range(0, 3));
            e_wr_reg = 5'($urandom_range(0, 3));
            d_use_rs = 1'($urandom_range(0, 1));
            d_use_rt = 1'($urandom_range(0, 1));
            e_is_load = 1'($urandom_range(0, 1));
            d_is_md = ($urandom_range(0, 7) == 0);
            d_md_div = 1'($urandom_range(0, 1));
            d_reads_hilo = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // drive the stall counter into saturation
        clear_inputs();
        for (int i = 0; i < 12; i++) step("drain");
        imem_ready = 0;
        for (int i = 0; i < 70000 && stall_model < 65535; i++) step("sat_fill");
        for (int i = 0; i < 4; i++) begin
            step("sat_hold");
            #1;
            chk("sat_hold.stall", stall_cycles, 16'hFFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the fetch/decode/execute front end. Generates enable/flush controls for the F/D pipeline register, the D/E pipeline register and the PC. Detects load-use hazards, kills wrong-path fetches on taken branches and absorbs instruction-memory wait states. Tracks the occupancy of the multi-cycle mult/div unit, stalls HI/LO consumers, and keeps a stall-cycle performance counter.

Parameters:
MUL_LAT, 5, cycles the mult/div unit is busy after a multiply is accepted
DIV_LAT, 10, cycles the mult/div unit is busy after a divide is accepted
CNT_W, 4, width of the busy countdown; must hold max(MUL_LAT, DIV_LAT)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
d_rs  input  5  rs field of the instruction in D
d_rt  input  5  rt field of the instruction in D
d_use_rs  input  1  D instruction reads rs
d_use_rt  input  1  D instruction reads rt
d_is_md  input  1  D instruction is mult/multu/div/divu
d_md_div  input  1  qualifies d_is_md: 1 = divide, 0 = multiply
d_reads_hilo  input  1  D instruction is mfhi/mflo/mthi/mtlo
e_wr_reg  input  5  destination register of the instruction in E
e_is_load  input  1  E instruction is a load
branch_taken  input  1  branch/jump in D resolved taken this cycle
imem_ready  input  1  instruction memory returns valid data this cycle
pc_en  output  1  PC load enable
fd_en  output  1  F/D register load enable
fd_flush  output  1  F/D register loads a NOP (0); wins over fd_en
de_flush  output  1  D/E register loads a bubble
md_busy  output  1  mult/div unit occupied
md_done  output  1  one-cycle pulse, result ready in HI/LO
stall_cycles  output  16  saturating count of cycles with pc_en = 0

Behaviour:
- Reset state: md_cnt = 0, md_done = 0, stall_cycles = 0. While reset = 0: pc_en = 0, fd_en = 0, fd_flush = 1, de_flush = 1.
- load_use = e_is_load & (e_wr_reg != 0) & ((d_use_rs & d_rs == e_wr_reg) | (d_use_rt & d_rt == e_wr_reg)).
- md_stall = md_busy & (d_reads_hilo | d_is_md). There is no back-to-back issue into a busy unit.
- hazard = load_use | md_stall.
- Control outputs are combinational, same cycle, evaluated in this priority order:
  1. hazard: pc_en = 0, fd_en = 0, fd_flush = 0, de_flush = 1. branch_taken is ignored because D re-evaluates next cycle.
  2. else branch_taken: pc_en = 1, fd_en = 1, fd_flush = 1, de_flush = 0. Applies regardless of imem_ready; the fetch restarts at the target. There is no delay slot.
  3. else !imem_ready: pc_en = 0, fd_en = 1, fd_flush = 1, de_flush = 0. D advances and a NOP enters D.
  4. else: pc_en = 1, fd_en = 1, fd_flush = 0, de_flush = 0.
- Mult/div tracking has two states, IDLE (md_cnt == 0) and BUSY (md_cnt != 0). md_busy = (md_cnt != 0).
  - Accept condition: d_is_md & !hazard at a rising edge. On accept, md_cnt <= d_md_div ? DIV_LAT : MUL_LAT.
  - Otherwise, if md_cnt != 0, md_cnt decrements every edge. It decrements through pipeline stalls and wait states.
  - md_done is registered. It is 1 for exactly the one cycle after md_cnt goes 1 -> 0.
  - Accept is impossible while BUSY, since md_stall blocks it.
- stall_cycles increments on every edge where pc_en = 0 and reset = 1. It saturates at 0xFFFF.
- Register 0 is never a hazard source (e_wr_reg = 0 suppresses load_use).
- Reset mid-operation: md_cnt clears immediately and asynchronously; the pending md_done is never issued.

Test Plan:
- Load-use: e_is_load = 1, e_wr_reg = 8, d_rs = 8, d_use_rs = 1 -> pc_en = 0, fd_en = 0, de_flush = 1 for that cycle. Repeat with e_wr_reg = 0 -> no stall. Repeat with d_use_rs = 0 -> no stall.
- Multiply then mflo: mult accepted at edge t -> md_busy high for 5 cycles. mflo held in D gets de_flush = 1 and pc_en = 0 for those 5 cycles, proceeds in cycle 6. md_done pulses once. stall_cycles = 5.
- Divide then divide: second div stalls for 10 cycles, is accepted at the edge when md_cnt = 0, and reloads md_cnt = 10.
- Branch with imem wait: branch_taken = 1, imem_ready = 0 -> pc_en = 1, fd_flush = 1. Next cycle imem_ready = 0, no branch -> pc_en = 0, fd_flush = 1, stall_cycles increments.
- Priority: load_use and branch_taken asserted together -> hazard response only (fd_flush = 0, de_flush = 1). Branch response the following cycle once the hazard clears.
- Reset during BUSY: div accepted, reset pulled low after 3 cycles -> md_busy = 0 immediately. No md_done pulse after release. stall_cycles = 0. Also force 0xFFFF stall cycles -> counter holds at 0xFFFF.
